mem_fabric: RTL
===============

MEM_FABRIC -- requirements
Module: mem_fabric

Interface
REQ-001 SHALL take parameter NSLV, default 8, giving the number of slave channels (1..16).
REQ-002 SHALL take parameter BASE, default 0, as NSLV packed 32-bit base addresses, where slave i is BASE[32i+:32].
REQ-003 SHALL take parameter MASK, default 0, as NSLV packed 32-bit compare masks, where slave i matches when (m_addr & MASK_i) == BASE_i.
REQ-004 SHALL take parameter TIMEOUT, default 255, giving the slave-response cycle limit (1..65535).
REQ-005 SHALL take parameter ERR_DATA, default 32'hDEAD_BEEF, giving the read data returned on any error.
REQ-006 SHALL use one clock and an asynchronous, active-low reset; ports are listed below.
- clk  in  1  clock; all state on rising edge
- resetn  in  1  asynchronous active-low reset
- m_valid  in  1  master request; held until m_ready
- m_addr  in  32  master address
- m_wdata  in  32  master write data
- m_wstrb  in  4  byte strobes; 0 means read
- m_ready  out  1  one-cycle completion pulse
- m_rdata  out  32  read data; valid only while m_ready=1
- s_valid  out  NSLV  one-hot slave select
- s_addr / s_wdata / s_wstrb  out  32/32/4  registered request, shared by all slaves
- s_ready  in  NSLV  per-slave completion
- s_rdata  in  NSLV*32  per-slave read data
- err_clr  in  1  clears the sticky error state
- err_irq  out  1  sticky error flag
- err_addr  out  32  address of the first error since the last clear
- err_cnt  out  8  saturating error counter

Function
REQ-007 SHALL implement a three-state FSM with states IDLE, ACTIVE and RESP, and SHALL allow one transaction in flight.
REQ-008 In IDLE with m_valid=1, SHALL register m_addr, m_wdata and m_wstrb, and SHALL decode the slave index with the lowest matching index winning.
REQ-009 On a decode hit, SHALL go to ACTIVE with s_valid[sel]=1 from the next cycle.
REQ-010 On a decode miss, SHALL go directly to RESP as an error.
REQ-011 In ACTIVE, SHALL hold s_valid[sel] and the s_* outputs stable, and SHALL ignore s_ready bits of unselected slaves.
REQ-012 In ACTIVE with s_ready[sel]=1, SHALL capture s_rdata[sel], drop s_valid and go to RESP.
REQ-013 In ACTIVE, SHALL increment a 16-bit timeout counter each cycle; when the counter reaches TIMEOUT-1 with s_ready[sel]=0, SHALL drop s_valid and go to RESP as an error.
REQ-014 If s_ready[sel] and the timeout occur in the same cycle, SHALL treat the transaction as a normal completion.
REQ-015 In RESP, SHALL assert m_ready for exactly one cycle with m_rdata set to the captured data, or to ERR_DATA on error, and SHALL then return to IDLE.
REQ-016 SHALL spend at least one cycle in IDLE between transactions; the master deasserts m_valid the cycle after m_ready.
REQ-017 Latency SHALL be 2 cycles plus the slave latency for a hit, 2 cycles for a miss, and TIMEOUT+2 cycles for a timeout.
REQ-018 On any error, SHALL set err_irq, SHALL latch err_addr only if err_irq was previously 0, and SHALL increment err_cnt, saturating at 255.
REQ-019 err_clr SHALL clear err_irq, err_addr and err_cnt; if an error occurs in the same cycle, the new error wins, leaving err_irq=1, err_addr set to the new address and err_cnt=1.
REQ-020 A write that hits SHALL return m_rdata=0.
REQ-021 A write error SHALL still report through err_irq, err_addr and err_cnt.
REQ-022 m_rdata SHALL be 0 whenever m_ready=0.

Reset
REQ-023 Asserting resetn=0 SHALL force, asynchronously: state IDLE, s_valid=0, m_ready=0, m_rdata=0, s_addr/s_wdata/s_wstrb=0, err_irq=0, err_addr=0, err_cnt=0, timeout counter 0.
REQ-024 Reset asserted mid-transaction SHALL abandon the transaction without producing an m_ready pulse.

Structure
REQ-025 Package mem_fabric_pkg SHALL hold the FSM state encoding, the ERR_DATA default and the timeout counter width.
REQ-026 Address decode SHALL be a sub-module mem_fabric_decode (NSLV, BASE, MASK parameters; outputs hit and sel index).

Verification
REQ-027 NSLV=4, slave 1 at BASE 0x2000_0000 / MASK 0xFF00_0000 with 1-cycle s_ready returning 0x1234_5678; read 0x2000_0010 -> s_valid=4'b0010, m_ready 3 cycles after m_valid, m_rdata=0x1234_5678.
REQ-028 Read of unmapped address 0x5000_0000 -> m_ready after 2 cycles, m_rdata=0xDEAD_BEEF, err_irq=1, err_addr=0x5000_0000, err_cnt=1.
REQ-029 TIMEOUT=8 with the slave never ready -> s_valid drops after 8 cycles, m_ready at cycle 10, m_rdata=ERR_DATA.
REQ-030 Overlapping windows on slaves 0 and 2 -> slave 0 is selected.
REQ-031 s_ready on the timeout cycle -> normal completion with no error.
REQ-032 err_clr coincident with a new miss -> err_cnt=1 and err_addr set to the new address.
REQ-033 256 errors -> err_cnt=255.
REQ-034 resetn pulsed low while in ACTIVE -> s_valid=0 immediately and no m_ready pulse.

Source files
------------

// File: rtl/mem_fabric_pkg.sv
// Shared types and constants for the single-outstanding memory fabric.
// Holds the FSM encoding, error data default and counter widths.
package mem_fabric_pkg;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_RESP
  } state_t;

  localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;
  localparam int TCNT_W = 16;
  localparam int SEL_W  = 4;

endpackage

// File: rtl/mem_fabric_decode.sv
// Address window decoder for the memory fabric.
// Reports a hit and the lowest-indexed matching slave.
module mem_fabric_decode
  import mem_fabric_pkg::*;
#(
  parameter int              NSLV = 8,
  parameter logic [NSLV*32-1:0] BASE = '0,
  parameter logic [NSLV*32-1:0] MASK = '0
) (
  input  logic [31:0]      i_addr,
  output logic             o_hit,
  output logic [SEL_W-1:0] o_sel
);

  // Scan downward so the lowest matching index is the last one written.
  always_comb begin
    o_hit = 1'b0;
    o_sel = '0;
    for (int i = NSLV - 1; i >= 0; i--) begin
      if ((i_addr & MASK[32*i +: 32]) == BASE[32*i +: 32]) begin
        o_hit = 1'b1;
        o_sel = SEL_W'(i);
      end
    end
  end

endmodule

// File: rtl/mem_fabric.sv
// Single-master to NSLV-slave memory fabric with timeout and sticky
// error reporting; one transaction in flight.
module mem_fabric
  import mem_fabric_pkg::*;
#(
  parameter int                 NSLV     = 8,
  parameter logic [NSLV*32-1:0] BASE     = '0,
  parameter logic [NSLV*32-1:0] MASK     = '0,
  parameter int                 TIMEOUT  = 255,
  parameter logic [31:0]        ERR_DATA = ERR_DATA_DEF
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 m_valid,
  input  logic [31:0]          m_addr,
  input  logic [31:0]          m_wdata,
  input  logic [3:0]           m_wstrb,
  output logic                 m_ready,
  output logic [31:0]          m_rdata,
  output logic [NSLV-1:0]      s_valid,
  output logic [31:0]          s_addr,
  output logic [31:0]          s_wdata,
  output logic [3:0]           s_wstrb,
  input  logic [NSLV-1:0]      s_ready,
  input  logic [NSLV*32-1:0]   s_rdata,
  input  logic                 err_clr,
  output logic                 err_irq,
  output logic [31:0]          err_addr,
  output logic [7:0]           err_cnt
);

  state_t            r_state;
  logic [NSLV-1:0]   r_sv;
  logic [31:0]       r_addr;
  logic [31:0]       r_wdata;
  logic [3:0]        r_wstrb;
  logic [TCNT_W-1:0] r_tcnt;
  logic [31:0]       r_cap;
  logic              r_err;
  logic              r_mrdy;
  logic [31:0]       r_mrdata;
  logic              r_irq;
  logic [31:0]       r_eaddr;
  logic [7:0]        r_ecnt;

  logic              w_hit;
  logic [SEL_W-1:0]  w_sel;
  logic [NSLV-1:0]   w_onehot;
  logic              w_srdy;
  logic [31:0]       w_srdata;
  logic              w_accept;
  logic              w_tout;
  logic              w_new_err;
  logic [31:0]       w_err_addr;

  mem_fabric_decode #(
    .NSLV (NSLV),
    .BASE (BASE),
    .MASK (MASK)
  ) u_dec (
    .i_addr (m_addr),
    .o_hit  (w_hit),
    .o_sel  (w_sel)
  );

  always_comb begin
    w_onehot = '0;
    for (int i = 0; i < NSLV; i++)
      w_onehot[i] = (w_sel == SEL_W'(i));
  end

  // r_sv is one-hot, so masking isolates the selected slave.
  always_comb begin
    w_srdata = '0;
    for (int i = 0; i < NSLV; i++)
      if (r_sv[i])
        w_srdata = w_srdata | s_rdata[32*i +: 32];
  end

  assign w_srdy = |(s_ready & r_sv);

  // The m_ready cycle is still IDLE; blocking it forces an idle gap.
  assign w_accept = (r_state == S_IDLE) && m_valid && !r_mrdy;

  assign w_tout = (r_state == S_ACTIVE) && !w_srdy &&
                  (r_tcnt == TCNT_W'(TIMEOUT - 1));

  assign w_new_err  = (w_accept && !w_hit) || w_tout;
  assign w_err_addr = w_accept ? m_addr : r_addr;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state  <= S_IDLE;
      r_sv     <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_wstrb  <= '0;
      r_tcnt   <= '0;
      r_cap    <= '0;
      r_err    <= 1'b0;
      r_mrdy   <= 1'b0;
      r_mrdata <= '0;
    end else begin
      r_mrdy   <= 1'b0;
      r_mrdata <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_addr  <= m_addr;
            r_wdata <= m_wdata;
            r_wstrb <= m_wstrb;
            r_tcnt  <= '0;
            if (w_hit) begin
              r_sv    <= w_onehot;
              r_state <= S_ACTIVE;
            end else begin
              r_err   <= 1'b1;
              r_state <= S_RESP;
            end
          end
        end
        S_ACTIVE: begin
          r_tcnt <= r_tcnt + 1'b1;
          if (w_srdy) begin
            r_sv    <= '0;
            r_cap   <= (r_wstrb == 4'd0) ? w_srdata : 32'd0;
            r_err   <= 1'b0;
            r_state <= S_RESP;
          end else if (w_tout) begin
            r_sv    <= '0;
            r_err   <= 1'b1;
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          r_mrdy   <= 1'b1;
          r_mrdata <= r_err ? ERR_DATA : r_cap;
          r_state  <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // A new error outranks a simultaneous clear.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_irq   <= 1'b0;
      r_eaddr <= '0;
      r_ecnt  <= '0;
    end else if (w_new_err) begin
      r_irq <= 1'b1;
      if (err_clr || !r_irq)
        r_eaddr <= w_err_addr;
      if (err_clr)
        r_ecnt <= 8'd1;
      else if (r_ecnt != 8'hFF)
        r_ecnt <= r_ecnt + 8'd1;
    end else if (err_clr) begin
      r_irq   <= 1'b0;
      r_eaddr <= '0;
      r_ecnt  <= '0;
    end
  end

  assign m_ready  = r_mrdy;
  assign m_rdata  = r_mrdata;
  assign s_valid  = r_sv;
  assign s_addr   = r_addr;
  assign s_wdata  = r_wdata;
  assign s_wstrb  = r_wstrb;
  assign err_irq  = r_irq;
  assign err_addr = r_eaddr;
  assign err_cnt  = r_ecnt;

endmodule
